siso_shift_ctrl: RTL and testbench

Sequencer for an external WIDTH-deep serial-in/serial-out shift register. Accepts parallel words over a valid/ready handshake, drives them MSB-first into the register's serial input with a shift enable, and collects the word emerging on the register's serial output. It returns that word on a parallel output. A flush request drains the register with zeros. It sits between a parallel producer/consumer and the SISO delay line.

---
 rtl/siso_shift_ctrl.sv | 130 +++++++++++++
 tb/tb_siso_shift_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/siso_shift_ctrl.sv
// rtl/siso_shift_ctrl.sv - parallel word sequencer for an external WIDTH-deep SISO shift register
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (shared with the external register)
//   din        parallel word to send, qualified by din_valid / din_ready
//   flush      drain request, honoured only in IDLE while the register holds a word
//   sdi        serial bit into the register (bit 0 side), MSB of the word first
//   shift_en   register shift enable, high for WIDTH consecutive cycles per word
//   sdo        register MSB stage, sampled before each shift edge
//   dout       word that left the register, held until the next completion
//   dout_valid one-cycle pulse on the first IDLE cycle after a completed word
//   busy       high while shifting or flushing
//   frame_cnt  accepted-word count, wraps silently
module siso_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             flush,
  output logic             sdi,
  output logic             shift_en,
  input  logic             sdo,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           state;
  logic [BW-1:0]    cnt;
  // Shadow is consumed MSB-first by shifting it left, so the next bit to send
  // is always shadow[WIDTH-1].
  logic [WIDTH-1:0] shadow;
  // Capture keeps only the low WIDTH-1 bits; the final bit comes straight
  // from sdo on the completing edge.
  logic [WIDTH-2:0] capture;
  logic             occupied;

  logic             last_bit;
  logic [WIDTH-1:0] cap_next;

  assign last_bit = (cnt == BW'(WIDTH - 1));
  assign cap_next = {capture, sdo};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shadow     <= '0;
      capture    <= '0;
      occupied   <= 1'b0;
      din_ready  <= 1'b1;
      shift_en   <= 1'b0;
      sdi        <= 1'b0;
      busy       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // New data wins over a simultaneous flush request.
          if (din_valid) begin
            shadow    <= {din[WIDTH-2:0], 1'b0};
            sdi       <= din[WIDTH-1];
            cnt       <= '0;
            frame_cnt <= frame_cnt + 1'b1;
            state     <= S_SHIFT;
            din_ready <= 1'b0;
            shift_en  <= 1'b1;
            busy      <= 1'b1;
          end else if (flush && occupied) begin
            sdi       <= 1'b0;
            cnt       <= '0;
            state     <= S_FLUSH;
            din_ready <= 1'b0;
            shift_en  <= 1'b1;
            busy      <= 1'b1;
          end
        end

        S_SHIFT, S_FLUSH: begin
          capture <= cap_next[WIDTH-2:0];
          if (last_bit) begin
            dout       <= cap_next;
            // Only a register that already held a word delivers one.
            dout_valid <= occupied;
            occupied   <= (state == S_SHIFT);
            state      <= S_IDLE;
            din_ready  <= 1'b1;
            shift_en   <= 1'b0;
            sdi        <= 1'b0;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == S_SHIFT) begin
              sdi    <= shadow[WIDTH-1];
              shadow <= {shadow[WIDTH-2:0], 1'b0};
            end else begin
              sdi <= 1'b0;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          din_ready <= 1'b1;
          shift_en  <= 1'b0;
          sdi       <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// tb/tb_siso_shift_ctrl.sv - self-checking bench for siso_shift_ctrl with a behavioural SISO register
module tb_siso_shift_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic             flush = 1'b0;
  logic             sdi;
  logic             shift_en;
  logic             sdo;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;

  siso_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .flush      (flush),
    .sdi        (sdi),
    .shift_en   (shift_en),
    .sdo        (sdo),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // External SISO register: sdi enters bit 0, sdo is the MSB stage.
  logic [WIDTH-1:0] sr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      sr <= '0;
    else if (shift_en) sr <= {sr[WIDTH-2:0], sdi};
  end
  assign sdo = sr[WIDTH-1];

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit               is_flush;
    logic [WIDTH-1:0] w;
    bit               with_flush;
    bit               keep;
    bit               exp_shift;
    bit               exp_valid;
    logic [WIDTH-1:0] exp_dout;
    logic [CNT_W-1:0] exp_frame;
  } vec_t;

  vec_t tbl[8];

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic do_op(input vec_t v);
    logic [WIDTH-1:0] sent;
    int n;
    sent = v.is_flush ? '0 : v.w;
    if (v.is_flush) begin
      din_valid = 1'b0;
      flush     = 1'b1;
    end else begin
      din       = v.w;
      din_valid = 1'b1;
      flush     = v.with_flush;
    end
    n = 0;
    while (!din_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("no_wait_before_accept", n, 0);
    if (v.exp_valid) sb.push_back(v.exp_dout);
    @(negedge clk);
    if (!v.keep) din_valid = 1'b0;
    flush = 1'b0;
    if (v.exp_shift) begin
      for (int i = 0; i < WIDTH; i++) begin
        check("shift_en_high", shift_en, 1);
        check("din_ready_low", din_ready, 0);
        check("busy_high", busy, 1);
        check("sdi_bit", sdi, sent[WIDTH-1-i]);
        @(negedge clk);
      end
      check("ready_after", din_ready, 1);
      check("shift_en_after", shift_en, 0);
      check("sdi_after", sdi, 0);
      check("dout_valid_timing", dout_valid, v.exp_valid);
      if (v.exp_valid) check("dout_value", dout, v.exp_dout);
    end else begin
      for (int i = 0; i < 6; i++) begin
        check("noop_shift_en", shift_en, 0);
        check("noop_busy", busy, 0);
        check("noop_dout_valid", dout_valid, 0);
        @(negedge clk);
      end
    end
    check("frame_cnt", frame_cnt, v.exp_frame);
  endtask

  always @(negedge clk) begin
    if (reset_n && dout_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: dout_valid with dout=%0h, expected no output", dout);
      end else begin
        check("sb_dout", dout, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] prev;
    vec_t v;

    tbl[0] = '{1'b0, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd1};
    tbl[1] = '{1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 3'd2};
    tbl[2] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, 3'd2};
    tbl[3] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd2};
    tbl[4] = '{1'b0, 4'hA,    1'b0, 1'b1, 1'b1, 1'b0, 4'h0,    3'd3};
    tbl[5] = '{1'b0, 4'h5,    1'b0, 1'b1, 1'b1, 1'b1, 4'hA,    3'd4};
    tbl[6] = '{1'b0, 4'hF,    1'b1, 1'b0, 1'b1, 1'b1, 4'h5,    3'd5};
    tbl[7] = '{1'b1, 4'h0,    1'b0, 1'b0, 1'b1, 1'b1, 4'hF,    3'd5};

    repeat (3) @(negedge clk);
    check("rst_din_ready", din_ready, 1);
    check("rst_shift_en", shift_en, 0);
    check("rst_dout", dout, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_din_ready", din_ready, 1);
      check("idle_shift_en", shift_en, 0);
      check("idle_sdi", sdi, 0);
      check("idle_dout_valid", dout_valid, 0);
      check("idle_frame_cnt", frame_cnt, 0);
    end

    for (int i = 0; i < 8; i++) do_op(tbl[i]);

    // Abort a word with reset on its second shift cycle.
    do_op('{1'b0, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd6});
    din = 4'b1100;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check("abort_sdi_cycle1", sdi, 1);
    @(negedge clk);
    check("abort_shift_en_cycle2", shift_en, 1);
    reset_n = 1'b0;
    #1;
    check("async_din_ready", din_ready, 1);
    check("async_shift_en", shift_en, 0);
    check("async_sdi", sdi, 0);
    check("async_busy", busy, 0);
    check("async_dout", dout, 0);
    check("async_dout_valid", dout_valid, 0);
    check("async_frame_cnt", frame_cnt, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_op('{1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd1});

    // Back-to-back words through frame_cnt wrap.
    prev = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      v = '{1'b0, WIDTH'(k * 3 + 2), 1'b0, 1'b0, 1'b1, 1'b1, prev, CNT_W'((2 + k) % 8)};
      do_op(v);
      prev = v.w;
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
